alu_rr_scheduler: RTL

Shares one combinational mini ALU (6-bit A/B operands, 3-bit fxn, 6-bit result x) between two requesters. Requesters issue operations over a valid/ready handshake. The block arbitrates between them round-robin, registers the operands and function code onto the ALU inputs, and holds them for a programmable settle time. It then samples the ALU result and returns it with a one-cycle response strobe to the requester that issued the operation.

---
 rtl/alu_sched_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_rr_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: state encoding,
// default widths and requester ids.
package alu_sched_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_FXN_W  = 3;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] EXEC_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE_ENC,
    S_EXEC = EXEC_ENC,
    S_DONE = DONE_ENC
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0_ID = 1'b0;
  localparam req_id_t REQ1_ID = 1'b1;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin grant; the pointer is held by the caller.
module rr_arb2
  import alu_sched_pkg::*;
(
  input  logic    i_valid0,
  input  logic    i_valid1,
  input  req_id_t i_ptr,
  output logic    o_gnt_valid,
  output req_id_t o_gnt_id
);

  always_comb begin
    o_gnt_valid = i_valid0 | i_valid1;
    o_gnt_id    = REQ0_ID;
    if (i_valid0 && i_valid1) begin
      o_gnt_id = i_ptr;
    end else if (i_valid1) begin
      o_gnt_id = REQ1_ID;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// hold operands for SETTLE cycles, then return the result with a strobe.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FXN_W  = DEF_FXN_W,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FXN_W-1:0]  req0_fxn,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FXN_W-1:0]  req1_fxn,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_x,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FXN_W-1:0]  alu_fxn,
  input  logic [DATA_W-1:0] alu_x,
  output logic              busy
);

  if (SETTLE < 1) begin : g_settle_check
    $error("alu_rr_scheduler: SETTLE must be >= 1");
  end

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  req_id_t           r_rr_ptr;
  req_id_t           r_owner;
  req_id_t           w_gnt_id;
  logic              w_gnt_valid;
  logic              w_accept;
  logic              w_cnt_zero;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [FXN_W-1:0]  r_alu_fxn;
  logic [DATA_W-1:0] r_rsp_x;

  rr_arb2 u_arb (
    .i_valid0    (req0_valid),
    .i_valid1    (req1_valid),
    .i_ptr       (r_rr_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no branch can infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = w_gnt_valid && (w_gnt_id == REQ0_ID);
        req1_ready = w_gnt_valid && (w_gnt_id == REQ1_ID);
        w_accept   = w_gnt_valid;
        if (w_gnt_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (w_cnt_zero) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        rsp0_valid  = (r_owner == REQ0_ID);
        rsp1_valid  = (r_owner == REQ1_ID);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured only on acceptance, so requester changes in flight are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fxn <= '0;
      r_owner   <= REQ0_ID;
      r_cnt     <= '0;
      r_rsp_x   <= '0;
      r_rr_ptr  <= REQ0_ID;
    end else begin
      if (w_accept) begin
        r_alu_a   <= (w_gnt_id == REQ1_ID) ? req1_a   : req0_a;
        r_alu_b   <= (w_gnt_id == REQ1_ID) ? req1_b   : req0_b;
        r_alu_fxn <= (w_gnt_id == REQ1_ID) ? req1_fxn : req0_fxn;
        r_owner   <= w_gnt_id;
        r_cnt     <= CNT_LOAD;
      end
      if (r_state == S_EXEC) begin
        if (w_cnt_zero) r_rsp_x <= alu_x;
        else            r_cnt   <= r_cnt - CNT_W'(1);
      end
      // Pointer always moves past the owner, even if the other side is idle.
      if (r_state == S_DONE) r_rr_ptr <= other_req(r_owner);
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_fxn = r_alu_fxn;
  assign rsp_x   = r_rsp_x;

endmodule
